// File: rtl/pip_fifo.sv
// pip_fifo: single-clock ADC sample FIFO with fill level, thresholds, registered read data and sticky error flags.
// Optional build macro PIP_FIFO_OVERWRITE_EN: a write while full without a read discards the oldest entry.
module pip_fifo #(
    parameter int          DATA_WIDTH    = 16,
    parameter int          ADDR_WIDTH    = 15,
    parameter int unsigned AFULL_THRESH  = (1 << ADDR_WIDTH) - 4,
    parameter int unsigned AEMPTY_THRESH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  q_valid,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                  DEPTH      = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LEVEL_ZERO = {(ADDR_WIDTH+1){1'b0}};
    localparam logic [ADDR_WIDTH:0] LEVEL_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] LEVEL_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH-1:0] PTR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_r;
    logic [ADDR_WIDTH-1:0] rd_ptr_r;
    logic [ADDR_WIDTH:0]   count_r;
    logic [DATA_WIDTH-1:0] q_r;
    logic                  q_valid_r;
    logic                  overflow_r;
    logic                  underflow_r;

    logic empty_s;
    logic full_s;
    logic rd_acc_s;
    logic wr_acc_s;
    logic ovw_s;
    logic rd_adv_s;
    logic cnt_up_s;
    logic cnt_dn_s;
    logic ovf_evt_s;
    logic unf_evt_s;

    // Accept decisions for the current cycle, derived from the registered occupancy.
    always_comb begin
        empty_s   = (count_r == LEVEL_ZERO);
        full_s    = (count_r == LEVEL_FULL);
        rd_acc_s  = start & rd & ~empty_s;
        ovf_evt_s = start & wr & full_s & ~rd;
        unf_evt_s = start & rd & empty_s;
`ifdef PIP_FIFO_OVERWRITE_EN
        // Full with no read: the write lands on the oldest slot and the read side skips past it.
        wr_acc_s  = start & wr;
        ovw_s     = ovf_evt_s;
`else
        wr_acc_s  = start & wr & (~full_s | rd);
        ovw_s     = 1'b0;
`endif
        rd_adv_s  = rd_acc_s | ovw_s;
        cnt_up_s  = wr_acc_s & ~rd_acc_s & ~ovw_s;
        cnt_dn_s  = rd_acc_s & ~wr_acc_s;
    end

    // Status decode from the registered count and register-to-port mapping.
    always_comb begin
        q            = q_r;
        q_valid      = q_valid_r;
        level        = count_r;
        empty        = empty_s;
        full         = full_s;
        almost_empty = (32'(count_r) <= AEMPTY_THRESH);
        almost_full  = (32'(count_r) >= AFULL_THRESH);
        overflow     = overflow_r;
        underflow    = underflow_r;
    end

    // Sample storage: no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_r[wr_ptr_r] <= data;
        end
    end

    // Registered read port; non-blocking read gives old data when the full FIFO reads and writes one slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r       <= DATA_ZERO;
            q_valid_r <= 1'b0;
        end else if (!start) begin
            q_r       <= DATA_ZERO;
            q_valid_r <= 1'b0;
        end else begin
            q_valid_r <= rd_acc_s;
            if (rd_acc_s) begin
                q_r <= mem_r[rd_ptr_r];
            end else begin
                q_r <= q_r;
            end
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= LEVEL_ZERO;
        end else if (!start) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= LEVEL_ZERO;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_adv_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({cnt_up_s, cnt_dn_s})
                2'b10:   count_r <= count_r + LEVEL_ONE;
                2'b01:   count_r <= count_r - LEVEL_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky error flags; only reset or a stop clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (!start) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            overflow_r  <= overflow_r | ovf_evt_s;
            underflow_r <= underflow_r | unf_evt_s;
        end
    end

endmodule

// File: tb/tb_pip_fifo.sv
// Self-checking bench for pip_fifo (DEPTH = 8): directed scenarios then biased random traffic,
// every cycle compared against a queue-based reference model.
module tb_pip_fifo;

    localparam int DW    = 16;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          wr    = 1'b0;
    logic          rd    = 1'b0;
    logic [DW-1:0] data  = 16'h0000;
    logic [DW-1:0] q;
    logic          q_valid, empty, full, almost_empty, almost_full, overflow, underflow;
    logic [AW:0]   level;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_q  = 16'h0000;
    logic          m_qv = 1'b0;
    logic          m_ov = 1'b0;
    logic          m_un = 1'b0;

    pip_fifo #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .wr(wr), .data(data), .rd(rd),
        .q(q), .q_valid(q_valid), .empty(empty), .full(full),
        .almost_empty(almost_empty), .almost_full(almost_full), .level(level),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_q  = 16'h0000;
        m_qv = 1'b0;
        m_ov = 1'b0;
        m_un = 1'b0;
    endtask

    task automatic model_step(input logic s, input logic w, input logic [DW-1:0] d, input logic r);
        int sz;
        sz = mq.size();
        if (!s) begin
            model_clear();
            return;
        end
        m_qv = 1'b0;
        if (r && sz > 0) begin
            m_q  = mq.pop_front();
            m_qv = 1'b1;
        end else if (r) begin
            m_un = 1'b1;
        end
        if (w) begin
            if (sz < DEPTH || r) begin
                mq.push_back(d);
            end else begin
                m_ov = 1'b1;
`ifdef PIP_FIFO_OVERWRITE_EN
                void'(mq.pop_front());
                mq.push_back(d);
`endif
            end
        end
    endtask

    task automatic check_all(input string t);
        int sz;
        sz = mq.size();
        chk({t, ".q"},            32'(q),            32'(m_q));
        chk({t, ".q_valid"},      32'(q_valid),      32'(m_qv));
        chk({t, ".level"},        32'(level),        32'(sz));
        chk({t, ".empty"},        32'(empty),        32'(sz == 0));
        chk({t, ".full"},         32'(full),         32'(sz == DEPTH));
        chk({t, ".almost_empty"}, 32'(almost_empty), 32'(sz <= AE));
        chk({t, ".almost_full"},  32'(almost_full),  32'(sz >= AF));
        chk({t, ".overflow"},     32'(overflow),     32'(m_ov));
        chk({t, ".underflow"},    32'(underflow),    32'(m_un));
    endtask

    task automatic cyc(input string t, input logic s, input logic w, input logic [DW-1:0] d, input logic r);
        start = s;
        wr    = w;
        data  = d;
        rd    = r;
        @(posedge clk);
        model_step(s, w, d, r);
        #1;
        check_all(t);
    endtask

    task automatic fill8(input string t);
        for (int i = 0; i < 8; i++) begin
            cyc(t, 1'b1, 1'b1, 16'h1000 + 16'(i), 1'b0);
        end
    endtask

    task automatic drain8(input string t);
        for (int i = 0; i < 8; i++) begin
            cyc(t, 1'b1, 1'b0, 16'h0000, 1'b1);
        end
    endtask

    initial begin
        logic [DW-1:0] rnd_d;
        int            wr_pct;
        int            rd_pct;

        #2;
        model_clear();
        check_all("reset");
        #11;
        rst_n = 1'b1;
        cyc("idle", 1'b1, 1'b0, 16'h0000, 1'b0);

        // Fill, then a refused (or overwriting) write, then drain.
        for (int i = 0; i < 8; i++) begin
            cyc("fill", 1'b1, 1'b1, 16'h1000 + 16'(i), 1'b0);
            if (i == 1) chk("fill.ae_at2", 32'(almost_empty), 32'd1);
            if (i == 2) chk("fill.ae_drop3", 32'(almost_empty), 32'd0);
            if (i == 5) chk("fill.af_rise6", 32'(almost_full), 32'd1);
        end
        chk("fill.full", 32'(full), 32'd1);
        chk("fill.level", 32'(level), 32'd8);
        cyc("ovf", 1'b1, 1'b1, 16'hDEAD, 1'b0);
        chk("ovf.flag", 32'(overflow), 32'd1);
        chk("ovf.level", 32'(level), 32'd8);
        drain8("ovf_drain");
        chk("ovf_drain.empty", 32'(empty), 32'd1);

        // Read while empty with a concurrent write: no bypass.
        cyc("unf", 1'b1, 1'b1, 16'h0042, 1'b1);
        chk("unf.flag", 32'(underflow), 32'd1);
        chk("unf.q_valid", 32'(q_valid), 32'd0);
        chk("unf.level", 32'(level), 32'd1);
        cyc("unf_rd", 1'b1, 1'b0, 16'h0000, 1'b1);
        chk("unf_rd.q", 32'(q), 32'h0042);

        cyc("clear", 1'b0, 1'b1, 16'h5555, 1'b1);
        chk("clear.ovf", 32'(overflow), 32'd0);
        chk("clear.unf", 32'(underflow), 32'd0);

        // Read and write together while full.
        fill8("sim_fill");
        cyc("sim", 1'b1, 1'b1, 16'h2000, 1'b1);
        chk("sim.q", 32'(q), 32'h1000);
        chk("sim.level", 32'(level), 32'd8);
        drain8("sim_drain");
        chk("sim_drain.last", 32'(q), 32'h2000);

        // Write while full without read (overwrite build keeps newest DEPTH words).
        cyc("clear2", 1'b0, 1'b0, 16'h0000, 1'b0);
        fill8("ow_fill");
        cyc("ow", 1'b1, 1'b1, 16'h3000, 1'b0);
        drain8("ow_drain");

        // Interleaved traffic across pointer wrap.
        cyc("clear3", 1'b0, 1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cyc("wrap", 1'b1, 1'b1, 16'(i), (i > 0));
        end
        cyc("wrap_end", 1'b1, 1'b0, 16'h0000, 1'b1);
        chk("wrap_end.q", 32'(q), 32'h0013);

        // Asynchronous reset between clock edges, mid-burst.
        cyc("burst", 1'b1, 1'b1, 16'hA001, 1'b0);
        cyc("burst", 1'b1, 1'b1, 16'hA002, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        model_clear();
        check_all("async_rst");
        chk("async_rst.q", 32'(q), 32'h0000);
        chk("async_rst.empty", 32'(empty), 32'd1);
        #2;
        rst_n = 1'b1;

        // Biased random traffic.
        for (int i = 0; i < 400; i++) begin
            wr_pct = ((i / 50) % 2 == 0) ? 75 : 30;
            rd_pct = ((i / 50) % 2 == 0) ? 30 : 75;
            rnd_d  = 16'($urandom);
            cyc("rand", ($urandom_range(0, 99) != 0), ($urandom_range(0, 99) < wr_pct), rnd_d,
                ($urandom_range(0, 99) < rd_pct));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
